// File: rtl/z80_tstate_seq.sv
// Z80 bus-cycle sequencer: steps T1..T4/TW on Clk4 edges (sampled in the Clk domain)
// and drives the active-low bus strobes for M1, memory read/write and I/O read cycles.
module z80_tstate_seq #(
    parameter int IO_AUTO_WAIT = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clk4,
    input  logic       Start,
    input  logic [1:0] CycleType,
    input  logic       Wait_n,
    output logic       Busy,
    output logic       Done,
    output logic       DataLatch,
    output logic [2:0] TState,
    output logic       M1_n,
    output logic       MREQ_n,
    output logic       IORQ_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       RFSH_n,
    output logic       AddrSel
);
    localparam logic [2:0] TS_IDLE = 3'd0, TS_T1 = 3'd1, TS_T2 = 3'd2,
                           TS_T3 = 3'd3, TS_T4 = 3'd4, TS_TW = 3'd7;
    localparam logic [1:0] CY_M1 = 2'd0, CY_MR = 2'd1, CY_MW = 2'd2, CY_IO = 2'd3;
    localparam logic [1:0] AW = 2'(IO_AUTO_WAIT);

    logic       c4_q;
    logic       rise, fall;
    logic [1:0] ctype;
    logic [1:0] aw_left;   // automatic I/O waits still to insert
    logic       wait_ok;   // last sampled Wait_n (1 when no sample was due)

    assign rise = Clk4 & ~c4_q;
    assign fall = ~Clk4 & c4_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            c4_q      <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DataLatch <= 1'b0;
            TState    <= TS_IDLE;
            ctype     <= CY_M1;
            aw_left   <= 2'd0;
            wait_ok   <= 1'b1;
            M1_n      <= 1'b1;
            MREQ_n    <= 1'b1;
            IORQ_n    <= 1'b1;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
            RFSH_n    <= 1'b1;
            AddrSel   <= 1'b0;
        end else begin
            c4_q      <= Clk4;
            Done      <= 1'b0;
            DataLatch <= 1'b0;
            // Acceptance edge never also steps state, so T1 waits for the following rise
            if (!Busy) begin
                if (Start) begin
                    Busy  <= 1'b1;
                    ctype <= CycleType;
                end
            end else if (rise) begin
                case (TState)
                    TS_IDLE: begin
                        TState <= TS_T1;
                        if (ctype == CY_M1) M1_n <= 1'b0;
                    end
                    TS_T1: begin
                        TState  <= TS_T2;
                        aw_left <= (ctype == CY_IO) ? AW : 2'd0;
                        wait_ok <= 1'b1;
                        if (ctype == CY_MW) WR_n <= 1'b0;
                        if (ctype == CY_IO) begin
                            IORQ_n <= 1'b0;
                            RD_n   <= 1'b0;
                        end
                    end
                    TS_T2, TS_TW: begin
                        if (aw_left != 2'd0) begin
                            TState  <= TS_TW;
                            aw_left <= aw_left - 2'd1;
                        end else if (!wait_ok) begin
                            TState <= TS_TW;
                        end else begin
                            TState <= TS_T3;
                            if (ctype == CY_M1) begin
                                DataLatch <= 1'b1;
                                M1_n      <= 1'b1;
                                MREQ_n    <= 1'b1;
                                RD_n      <= 1'b1;
                                RFSH_n    <= 1'b0;
                                AddrSel   <= 1'b1;
                            end
                        end
                    end
                    TS_T3: begin
                        if (ctype == CY_M1) begin
                            TState <= TS_T4;
                        end else begin
                            TState <= TS_IDLE;
                            Busy   <= 1'b0;
                            Done   <= 1'b1;
                        end
                    end
                    TS_T4: begin
                        TState  <= TS_IDLE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        RFSH_n  <= 1'b1;
                        AddrSel <= 1'b0;
                    end
                    default: TState <= TS_IDLE;
                endcase
            end else if (fall) begin
                case (TState)
                    TS_T1: begin
                        if (ctype != CY_IO) MREQ_n <= 1'b0;
                        if (ctype == CY_M1 || ctype == CY_MR) RD_n <= 1'b0;
                    end
                    // Wait is only honoured once the automatic I/O waits are used up
                    TS_T2, TS_TW: begin
                        if (aw_left == 2'd0) wait_ok <= Wait_n;
                    end
                    TS_T3: begin
                        case (ctype)
                            CY_M1: MREQ_n <= 1'b0;
                            CY_MR: begin
                                DataLatch <= 1'b1;
                                MREQ_n    <= 1'b1;
                                RD_n      <= 1'b1;
                            end
                            CY_MW: begin
                                MREQ_n <= 1'b1;
                                WR_n   <= 1'b1;
                            end
                            default: begin
                                DataLatch <= 1'b1;
                                IORQ_n    <= 1'b1;
                                RD_n      <= 1'b1;
                            end
                        endcase
                    end
                    TS_T4: MREQ_n <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_z80_tstate_seq.sv
// Directed bench for z80_tstate_seq: Clk4 from a divide-by-25 (12 high / 13 low),
// cycle timings checked relative to T1 entry.
module tb_z80_tstate_seq;
    logic       Clk = 1'b0;
    logic       Reset, Clk4, Start, Wait_n;
    logic [1:0] CycleType;
    logic       Busy, Done, DataLatch, M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, AddrSel;
    logic [2:0] TState;

    int n_checks = 0;
    int n_err    = 0;

    logic div_run = 1'b0;
    int   div_cnt = 11;

    // per-run records, cycle indices (-1 = never)
    int lo[7];
    int hi[7];
    int t1, tw_cnt, dl_cyc, dl_cnt, done_cyc;

    z80_tstate_seq #(.IO_AUTO_WAIT(1)) dut (
        .Clk(Clk), .Reset(Reset), .Clk4(Clk4), .Start(Start), .CycleType(CycleType),
        .Wait_n(Wait_n), .Busy(Busy), .Done(Done), .DataLatch(DataLatch), .TState(TState),
        .M1_n(M1_n), .MREQ_n(MREQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .RFSH_n(RFSH_n), .AddrSel(AddrSel)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (div_run) begin
            div_cnt = (div_cnt == 24) ? 0 : div_cnt + 1;
            Clk4 = (div_cnt < 12);
        end
    end

    function automatic logic [6:0] strobes();
        return {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, ~AddrSel};
    endfunction

    function automatic int rel(input int c);
        return (c < 0 || t1 < 0) ? -1 : c - t1;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps until Done (bounded); Wait_n low for relative cycles [wa,wb); Start pulsed at rel start_at.
    task automatic run_cycle(input int wa, input int wb, input int start_at);
        int n;
        int r;
        logic [2:0] prev_ts;
        logic [6:0] s;
        for (int k = 0; k < 7; k++) begin
            lo[k] = -1;
            hi[k] = -1;
        end
        t1 = -1; tw_cnt = 0; dl_cyc = -1; dl_cnt = 0; done_cyc = -1;
        n = 0;
        prev_ts = TState;
        while (done_cyc < 0 && n < 400) begin
            r = (t1 < 0) ? -1000 : n + 1 - t1;
            Wait_n = !(r >= wa && r < wb);
            Start  = (r == start_at);
            tick();
            n++;
            s = strobes();
            if (t1 < 0 && TState == 3'd1) t1 = n;
            if (TState == 3'd7 && prev_ts != 3'd7) tw_cnt++;
            prev_ts = TState;
            for (int k = 0; k < 7; k++) begin
                if (!s[k] && lo[k] < 0) lo[k] = n;
                if (s[k] && lo[k] >= 0 && hi[k] < 0) hi[k] = n;
            end
            if (DataLatch) begin
                dl_cnt++;
                dl_cyc = n;
            end
            if (Done) done_cyc = n;
        end
        Start  = 1'b0;
        Wait_n = 1'b1;
    endtask

    initial begin
        int bad;
        int cnt;
        Reset = 1'b1; Clk4 = 1'b1; Start = 1'b0; Wait_n = 1'b1; CycleType = 2'd0;
        repeat (3) tick();
        chk("rst_strobes", int'(strobes()), 7'h7F);
        chk("rst_busy", Busy, 0);
        chk("rst_tstate", TState, 0);
        chk("rst_done_dl", {Done, DataLatch}, 0);
        Reset = 1'b0;

        // Clk4 held high: idle stays quiet, and an accepted request cannot reach T1
        bad = 0;
        repeat (10) begin
            tick();
            if (strobes() != 7'h7F || Busy) bad++;
        end
        chk("idle_quiet", bad, 0);
        CycleType = 2'd1; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("accept_busy", Busy, 1);
        bad = 0;
        repeat (20) begin
            tick();
            if (TState != 0 || strobes() != 7'h7F) bad++;
        end
        chk("no_tick_c4_high", bad, 0);

        // memory read on the pending request
        div_run = 1'b1;
        run_cycle(-1, -1, -1);
        chk("mr_mreq_lo", rel(lo[5]), 12);
        chk("mr_mreq_hi", rel(hi[5]), 62);
        chk("mr_rd_lo", rel(lo[3]), 12);
        chk("mr_rd_hi", rel(hi[3]), 62);
        chk("mr_dl_at", rel(dl_cyc), 62);
        chk("mr_dl_cnt", dl_cnt, 1);
        chk("mr_done_at", rel(done_cyc), 75);
        chk("mr_no_tw", tw_cnt, 0);
        tick();
        chk("mr_done_pulse", {Done, Busy}, 0);

        // M1 with one wait state
        CycleType = 2'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        run_cycle(30, 40, -1);
        chk("m1_m1_lo", rel(lo[6]), 0);
        chk("m1_m1_hi", rel(hi[6]), 75);
        chk("m1_mreq_lo", rel(lo[5]), 12);
        chk("m1_mreq_hi", rel(hi[5]), 75);
        chk("m1_rd_hi", rel(hi[3]), 75);
        chk("m1_tw_cnt", tw_cnt, 1);
        chk("m1_dl_at", rel(dl_cyc), 75);
        chk("m1_rfsh_lo", rel(lo[1]), 75);
        chk("m1_rfsh_hi", rel(hi[1]), 125);
        chk("m1_asel_on", rel(lo[0]), 75);
        chk("m1_asel_off", rel(hi[0]), 125);
        chk("m1_done_at", rel(done_cyc), 125);

        // memory write
        CycleType = 2'd2; Start = 1'b1;
        tick();
        Start = 1'b0;
        run_cycle(-1, -1, -1);
        chk("mw_mreq_lo", rel(lo[5]), 12);
        chk("mw_mreq_hi", rel(hi[5]), 62);
        chk("mw_wr_lo", rel(lo[2]), 25);
        chk("mw_wr_hi", rel(hi[2]), 62);
        chk("mw_rd_never", lo[3], -1);
        chk("mw_dl_cnt", dl_cnt, 0);
        chk("mw_done_at", rel(done_cyc), 75);

        // I/O read issued on the Clk right after Done, with a stray mid-cycle Start
        CycleType = 2'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("io_accept_after_done", Busy, 1);
        run_cycle(-1, -1, 40);
        chk("io_iorq_lo", rel(lo[4]), 25);
        chk("io_iorq_hi", rel(hi[4]), 87);
        chk("io_rd_lo", rel(lo[3]), 25);
        chk("io_mreq_never", lo[5], -1);
        chk("io_tw_cnt", tw_cnt, 1);
        chk("io_dl_at", rel(dl_cyc), 87);
        chk("io_done_at", rel(done_cyc), 100);
        bad = 0;
        repeat (40) begin
            tick();
            if (Busy || TState != 0) bad++;
        end
        chk("io_start_ignored", bad, 0);

        // reset during TW of a memory read
        CycleType = 2'd1; Start = 1'b1;
        tick();
        Start = 1'b0;
        Wait_n = 1'b0;
        cnt = 0;
        while (TState != 3'd7 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("rst_reach_tw", TState, 7);
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midrst_strobes", int'(strobes()), 7'h7F);
        chk("midrst_busy_ts", {Busy, TState}, 0);
        chk("midrst_done_dl", {Done, DataLatch}, 0);
        Wait_n = 1'b1;
        bad = 0;
        repeat (30) begin
            tick();
            if (Done || DataLatch || Busy) bad++;
        end
        chk("midrst_no_done", bad, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        run_cycle(-1, -1, -1);
        chk("post_rst_done_at", rel(done_cyc), 75);
        chk("post_rst_tw", tw_cnt, 0);
        chk("post_rst_dl_at", rel(dl_cyc), 62);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/z80_tstate_seq.md
Name: z80_tstate_seq

Overview:
- Z80 bus-cycle sequencer, directly downstream of the clock divider.
- Samples the divider's Clk4 output in the Clk domain. Derives rise and fall ticks from it, and steps T-states (T1..T4, TW) on those ticks.
- Drives the active-low Z80 bus strobes for opcode fetch, memory read, memory write and I/O read cycles.
- The CPU core requests one machine cycle at a time via Start/CycleType and receives Done/DataLatch pulses back.

Parameters:
- IO_AUTO_WAIT, 1, number of automatic TW states inserted after T2 in I/O cycles (legal range 0..3).

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- Clk4  in  1  divided clock level from the clock divider; sampled as data, never used as a clock.
- Start  in  1  machine-cycle request; accepted only when Busy=0.
- CycleType  in  2  00 opcode fetch (M1), 01 memory read, 10 memory write, 11 I/O read; captured with Start.
- Wait_n  in  1  bus wait request, active low.
- Busy  out  1  high from acceptance until Done.
- Done  out  1  one-Clk pulse at end of cycle.
- DataLatch  out  1  one-Clk pulse; read data valid, core latches the bus.
- TState  out  3  0 idle, 1..4 = T1..T4, 7 = TW.
- M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n  out  1 each  Z80 strobes, active low.
- AddrSel  out  1  0 = cycle address, 1 = refresh address (during T3/T4 of M1 only).

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values:
  - Busy=0, Done=0, DataLatch=0, TState=0, AddrSel=0.
  - All strobes =1.
  - Clk4 sample register c4_q=1, so no rise tick is seen until Clk4 has been observed low.
- Ticks (combinational from registered c4_q):
  - rise = Clk4 & ~c4_q; fall = ~Clk4 & c4_q.
  - All state and strobe updates occur on the Clk edge where the tick is true.
  - Outputs therefore change one Clk after Clk4 transitions.
- Acceptance:
  - Start is sampled every Clk while Busy=0; on acceptance Busy=1 and CycleType is latched.
  - Start while Busy=1 is ignored.
  - T1 is entered at the next rise tick; TState stays 0 until then.
- Per-cycle strobe schedule ("Tn r/f" = rise/fall tick of Tn):
  - M1 (opcode fetch):
    - T1r: M1_n=0.
    - T1f: MREQ_n=0, RD_n=0.
    - T3r: DataLatch pulse; M1_n, MREQ_n, RD_n =1; RFSH_n=0; AddrSel=1.
    - T3f: MREQ_n=0.
    - T4f: MREQ_n=1.
    - End tick: RFSH_n=1, AddrSel=0.
  - Memory read:
    - T1f: MREQ_n=0, RD_n=0.
    - T3f: DataLatch pulse; MREQ_n=1, RD_n=1.
  - Memory write:
    - T1f: MREQ_n=0.
    - T2r: WR_n=0.
    - T3f: MREQ_n=1, WR_n=1.
  - I/O read:
    - T2r: IORQ_n=0, RD_n=0.
    - IO_AUTO_WAIT TW states are inserted unconditionally after T2.
    - T3f: DataLatch pulse; IORQ_n=1, RD_n=1.
- Wait handling:
  - Wait_n is sampled on the T2 fall tick, or on the last auto-TW fall tick for I/O.
  - If Wait_n=0, the next rise enters TW (TState=7).
  - In TW, Wait_n is resampled each fall tick; TW repeats until Wait_n=1 is sampled, then the next rise enters T3.
  - Wait stretching is unbounded. Strobes hold their values throughout TW.
  - Wait_n is ignored in all other T-states.
- End of cycle:
  - The rise tick after the last T-state (T4 for M1, T3 otherwise) ends the cycle: TState=0, Busy=0, Done=1 for one Clk.
  - A Start on the Clk after Done is accepted normally.
- Simultaneous rise and fall ticks are impossible (single Clk4 sample).
- If Clk4 stops, state holds indefinitely.
- Reset mid-cycle: all outputs return to reset values on the next Clk edge. No Done or DataLatch pulse; the latched request is discarded.

Test Plan:
- Reset with Clk4=1 held, then release → no tick until Clk4 goes 0 then 1; all strobes read 1 and Busy=0 throughout.
- Divider-driven Clk4 (period 25 Clk), memory read, Wait_n=1 → MREQ_n/RD_n low from T1f to T3f; DataLatch and Done each 1 Clk; Done exactly 75 Clk after T1 entry.
- M1 fetch with Wait_n=0 sampled at T2f then 1 → exactly one TW (TState=7); refresh window RFSH_n=0, AddrSel=1 spans T3r..end; Done 125 Clk after T1.
- Memory write → WR_n low only between T2r and T3f; MREQ_n low T1f..T3f; DataLatch never pulses.
- I/O read, IO_AUTO_WAIT=1, Wait_n=1 → IORQ_n low from T2r; one TW; DataLatch at T3f; Start pulsed mid-cycle is ignored (no second cycle).
- Reset asserted during TW of a memory read → next Clk all strobes =1, Busy=0, TState=0, no Done; a fresh Start afterwards runs a normal 3-T-state cycle.
